switch_capture: RTL and testbench
=================================

SWITCH_CAPTURE -- requirements
Module: switch_capture

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500_000, SHALL set the number of clk cycles a switch pattern must stay stable (10 ms at 50 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 250_000_000, SHALL set the number of clk cycles allowed for the player to respond once armed (5 s at 50 MHz).
REQ-004 Port clk, input, 1 bit, SHALL be the 50 MHz system clock; all state SHALL update on posedge clk.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-006 Port arm, input, 1 bit, SHALL be a one-cycle pulse from the game FSM requesting capture of one colour entry.
REQ-007 Port cancel, input, 1 bit, SHALL be a level that aborts any capture in progress.
REQ-008 Port player_input, input, 4 bits, SHALL carry the raw, asynchronous SW[3:0] colour switches.
REQ-009 Port colour, output, 2 bits, SHALL hold the index of the captured switch (SW[n] gives n).
REQ-010 Port valid, output, 1 bit, SHALL pulse for one cycle when colour is a newly captured entry.
REQ-011 Port multi, output, 1 bit, SHALL pulse for one cycle when a debounced pattern has two or more switches high.
REQ-012 Port timeout, output, 1 bit, SHALL pulse for one cycle when the response window expires.
REQ-013 Port busy, output, 1 bit, SHALL be high in every state except IDLE.

Function
REQ-014 The block SHALL pass player_input through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-015 The debouncer SHALL treat a pattern as stable once the synchronized value has matched the previous cycle for DEBOUNCE_CYCLES consecutive cycles; any change SHALL restart the count.
REQ-016 The state machine SHALL have exactly five states: IDLE, WAIT_RELEASE, WAIT_PRESS, HELD, DONE.
REQ-017 IDLE: on arm, the block SHALL load the timeout counter with TIMEOUT_CYCLES-1 and go to WAIT_RELEASE.
REQ-018 WAIT_RELEASE: when the stable pattern is 4'b0000, the block SHALL go to WAIT_PRESS; a switch already high when armed SHALL never be captured.
REQ-019 WAIT_PRESS, stable one-hot pattern: the block SHALL latch colour and go to HELD.
REQ-020 WAIT_PRESS, stable pattern with two or more bits set: the block SHALL pulse multi, keep colour unchanged, and go to WAIT_RELEASE.
REQ-021 HELD: when the stable pattern returns to 4'b0000, the block SHALL go to DONE; any other stable pattern while held SHALL be ignored.
REQ-022 DONE: the block SHALL assert valid for exactly one cycle and return to IDLE on the next cycle; valid SHALL therefore mark release, not press.
REQ-023 The timeout counter SHALL decrement once per cycle in WAIT_RELEASE, WAIT_PRESS and HELD.
REQ-024 When the timeout counter reaches 0 in any of those states, the block SHALL pulse timeout and go to IDLE with no valid.
REQ-025 If timeout expiry and the DONE transition fall in the same cycle, timeout SHALL win and valid SHALL NOT pulse.
REQ-026 While cancel is high, the block SHALL go to (or stay in) IDLE with no valid, multi or timeout pulse; cancel SHALL take priority over every other transition.
REQ-027 arm received outside IDLE SHALL be ignored.
REQ-028 valid, multi and timeout SHALL be mutually exclusive in any cycle.
REQ-029 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and the timeout counter $clog2(TIMEOUT_CYCLES) bits; neither counter SHALL wrap.

Reset
REQ-030 While reset is low at a clock edge, the block SHALL enter IDLE, set colour=2'b00 and valid=multi=timeout=busy=0, clear both counters, and clear the synchronizer flops and the stable pattern to 4'b0000.
REQ-031 Reset asserted mid-capture SHALL discard the partial entry and produce no output pulse.
REQ-032 The first arm honoured after reset SHALL be the first one sampled with reset high.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-033 Arm with all switches off, then hold SW=4'b0100 for 10 cycles and release -> valid pulses once, colour=2'd2, busy falls the cycle after valid.
REQ-034 Arm while SW=4'b0001 is held, release, then press and release 4'b1000 -> exactly one valid, with colour=2'd3.
REQ-035 Arm, press SW=4'b0110 stably, then release -> one multi pulse, no valid; a following 4'b0001 press/release -> valid with colour=2'd0.
REQ-036 Arm and toggle SW[1] every 2 cycles for 20 cycles, then off -> no valid or multi pulse.
REQ-037 Arm with no input for 100 cycles -> timeout pulses exactly once and busy drops; a second arm restarts the full 100-cycle window.
REQ-038 Arm, hold 4'b0010, then drive reset low for 1 cycle (or cancel high) before release -> no valid, IDLE, colour=2'b00 after reset.

Source files
------------

// File: rtl/switch_capture.sv
// Captures one colour entry from four raw switches: synchronize, debounce,
// wait for a clean release/press/release, and report the pressed switch index.
module switch_capture #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       cancel,
    input  logic [3:0] player_input,
    output logic [1:0] colour,
    output logic       valid,
    output logic       multi,
    output logic       timeout,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // Handshake: arm is a one-cycle request honoured only in IDLE; busy is high
    // from the cycle after an accepted arm until the block is back in IDLE, and
    // exactly one of valid/multi/timeout may pulse in any cycle.

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_RELEASE = 3'd1,
        WAIT_PRESS   = 3'd2,
        HELD         = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    samp_q, samp_d;
    logic [3:0]    stable_q, stable_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    colour_q, colour_d;
    logic          valid_q, valid_d;
    logic          multi_q, multi_d;
    logic          timeout_q, timeout_d;
    logic          stable_onehot;
    logic [1:0]    stable_idx;

    // Synchronizer and debouncer; the count saturates instead of wrapping.
    always_comb begin
        sync1_d   = player_input;
        sync2_d   = sync1_q;
        samp_d    = sync2_q;
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        if (sync2_q != samp_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
        if (deb_cnt_d == DEB_MAX) begin
            stable_d = sync2_q;
        end
    end

    always_comb begin
        stable_onehot = (stable_q != 4'b0000) && ((stable_q & (stable_q - 4'd1)) == 4'b0000);
        stable_idx    = 2'd0;
        case (stable_q)
            4'b0010: stable_idx = 2'd1;
            4'b0100: stable_idx = 2'd2;
            4'b1000: stable_idx = 2'd3;
            default: stable_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        colour_d  = colour_q;
        valid_d   = 1'b0;
        multi_d   = 1'b0;
        timeout_d = 1'b0;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        tmo_d   = TMO_LOAD;
                        state_d = WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE, WAIT_PRESS, HELD: begin
                    // Expiry is checked first so it beats a release in the same cycle.
                    if (tmo_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                        if (state_q == WAIT_RELEASE) begin
                            if (stable_q == 4'b0000) state_d = WAIT_PRESS;
                        end else if (state_q == WAIT_PRESS) begin
                            if (stable_onehot) begin
                                colour_d = stable_idx;
                                state_d  = HELD;
                            end else if (stable_q != 4'b0000) begin
                                multi_d = 1'b1;
                                state_d = WAIT_RELEASE;
                            end
                        end else begin
                            if (stable_q == 4'b0000) begin
                                valid_d = 1'b1;
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            samp_q    <= 4'b0000;
            stable_q  <= 4'b0000;
            deb_cnt_q <= '0;
            tmo_q     <= '0;
            colour_q  <= 2'b00;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samp_q    <= samp_d;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            tmo_q     <= tmo_d;
            colour_q  <= colour_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
            timeout_q <= timeout_d;
        end
    end

    assign colour    = colour_q;
    assign valid     = valid_q;
    assign multi     = multi_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_switch_capture.sv
// Self-checking bench for switch_capture with short debounce/timeout parameters.
module tb_switch_capture;

    localparam int DEB = 4;
    localparam int TMO = 100;
    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_MULTI = 2'd2;
    localparam logic [1:0] K_TMO   = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] player_input = 4'b0000;
    logic [1:0] colour;
    logic       valid, multi, timeout, busy;
    logic [2:0] state_dbg;

    int tests_run = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [1:0] exp_colour = 2'd0;

    switch_capture #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .arm(arm), .cancel(cancel),
        .player_input(player_input), .colour(colour), .valid(valid),
        .multi(multi), .timeout(timeout), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ev(input logic [1:0] kind, input logic [1:0] col);
        return {kind, col};
    endfunction

    // Scoreboard: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        logic [3:0] obs;
        logic [3:0] exp_v;
        if (reset && (valid || multi || timeout)) begin
            obs = {(valid ? K_VALID : (multi ? K_MULTI : K_TMO)), colour};
            tests_run++;
            if ($countones({valid, multi, timeout}) != 1) begin
                fails++;
                $display("FAIL exclusive: got valid/multi/timeout=%b required one-hot", {valid, multi, timeout});
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got kind/colour=%h required none", obs);
            end else begin
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL event: got kind/colour=%h required %h", obs, exp_v);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        tests_run++;
        if (busy) begin
            fails++;
            $display("FAIL %s_idle: got busy=1 after %0d cycles required 0", name, max);
        end
    endtask

    task automatic check_drained(input string name);
        tick(3);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d pending events required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        player_input = 4'b0000;
        tick(3);
        tests_run++;
        if ({busy, valid, multi, timeout, colour, state_dbg} !== 9'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {busy, valid, multi, timeout, colour, state_dbg});
        end
        reset = 1'b1;
        tick(2);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_press();
        int n = 0;
        player_input = 4'b0000;
        pulse_arm();
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy: got %b required 1", busy);
        end
        exp_q.push_back(ev(K_VALID, 2'd2));
        exp_colour = 2'd2;
        player_input = 4'b0100;
        tick(10);
        player_input = 4'b0000;
        while (!valid && n < 60) begin
            tick();
            n++;
        end
        tests_run++;
        if (!valid || busy !== 1'b1 || colour !== 2'd2) begin
            fails++;
            $display("FAIL single_valid: got valid=%b busy=%b colour=%0d required 1 1 2", valid, busy, colour);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_fall: got busy=%b valid=%b required 0 0", busy, valid);
        end
        check_drained("single");
    endtask

    task automatic test_held_at_arm();
        player_input = 4'b0001;
        tick(10);
        pulse_arm();
        exp_q.push_back(ev(K_VALID, 2'd3));
        exp_colour = 2'd3;
        tick(10);
        tests_run++;
        if (state_dbg !== 3'd1) begin
            fails++;
            $display("FAIL held_wait_release: got state=%0d required 1", state_dbg);
        end
        player_input = 4'b0000;
        tick(10);
        player_input = 4'b1000;
        tick(10);
        player_input = 4'b0000;
        wait_idle(40, "held");
        tests_run++;
        if (colour !== 2'd3) begin
            fails++;
            $display("FAIL held_colour: got %0d required 3", colour);
        end
        check_drained("held");
    endtask

    task automatic test_multi();
        pulse_arm();
        exp_q.push_back(ev(K_MULTI, exp_colour));
        player_input = 4'b0110;
        tick(10);
        player_input = 4'b0000;
        tick(10);
        tests_run++;
        if (exp_q.size() != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL multi_seen: got pending=%0d busy=%b required 0 1", exp_q.size(), busy);
        end
        exp_q.push_back(ev(K_VALID, 2'd0));
        exp_colour = 2'd0;
        player_input = 4'b0001;
        tick(10);
        player_input = 4'b0000;
        wait_idle(40, "multi");
        check_drained("multi");
    endtask

    task automatic test_bounce();
        pulse_arm();
        for (int i = 0; i < 10; i++) begin
            player_input[1] = ~player_input[1];
            tick(2);
        end
        player_input = 4'b0000;
        tick(15);
        tests_run++;
        if (busy !== 1'b1 || state_dbg !== 3'd2) begin
            fails++;
            $display("FAIL bounce_state: got busy=%b state=%0d required 1 2", busy, state_dbg);
        end
        cancel = 1'b1;
        tick(2);
        cancel = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL bounce_cancel: got busy=%b required 0", busy);
        end
        check_drained("bounce");
    endtask

    task automatic test_timeout();
        for (int r = 0; r < 2; r++) begin
            int n = 0;
            pulse_arm();
            exp_q.push_back(ev(K_TMO, exp_colour));
            while (!timeout && n < 150) begin
                tick();
                n++;
            end
            tests_run++;
            if (n != TMO || busy !== 1'b0) begin
                fails++;
                $display("FAIL timeout_window: got %0d cycles busy=%b required %0d 0", n, busy, TMO);
            end
            tick();
            tests_run++;
            if (timeout !== 1'b0) begin
                fails++;
                $display("FAIL timeout_pulse_len: got %b required 0", timeout);
            end
        end
        check_drained("timeout");
    endtask

    task automatic test_arm_ignored();
        pulse_arm();
        exp_q.push_back(ev(K_VALID, 2'd2));
        exp_colour = 2'd2;
        player_input = 4'b0100;
        tick(10);
        pulse_arm();
        tests_run++;
        if (state_dbg !== 3'd3) begin
            fails++;
            $display("FAIL arm_ignored_state: got %0d required 3", state_dbg);
        end
        player_input = 4'b0000;
        wait_idle(40, "arm_ignored");
        check_drained("arm_ignored");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = 2'($urandom_range(0, 3));
            pulse_arm();
            exp_q.push_back(ev(K_VALID, idx));
            exp_colour = idx;
            player_input = 4'b0001 << idx;
            tick(8);
            player_input = 4'b0000;
            wait_idle(40, "b2b");
            tests_run++;
            if (colour !== idx) begin
                fails++;
                $display("FAIL b2b_colour: got %0d required %0d", colour, idx);
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        player_input = 4'b0010;
        tick(10);
        tests_run++;
        if (state_dbg !== 3'd3 || colour !== 2'd1) begin
            fails++;
            $display("FAIL reset_mid_held: got state=%0d colour=%0d required 3 1", state_dbg, colour);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_colour = 2'd0;
        tests_run++;
        if (busy !== 1'b0 || colour !== 2'd0 || state_dbg !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_clear: got busy=%b colour=%0d state=%0d required 0 0 0", busy, colour, state_dbg);
        end
        tick(10);
        player_input = 4'b0000;
        tick(15);
        check_drained("reset_mid");
    endtask

    task automatic test_cancel();
        pulse_arm();
        player_input = 4'b0010;
        tick(10);
        exp_colour = 2'd1;
        tests_run++;
        if (colour !== exp_colour) begin
            fails++;
            $display("FAIL cancel_latched: got %0d required %0d", colour, exp_colour);
        end
        cancel = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL cancel_idle: got busy=%b required 0", busy);
        end
        pulse_arm();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL cancel_blocks_arm: got busy=%b required 0", busy);
        end
        cancel = 1'b0;
        player_input = 4'b0000;
        tick(15);
        check_drained("cancel");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_held_at_arm();
        test_multi();
        test_bounce();
        test_timeout();
        test_arm_ignored();
        test_back_to_back();
        test_reset_mid();
        test_cancel();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
